lz77_decompressor: RTL and testbench

- Receive end of the LZ77 serial token stream: accepts tokens MSB-first, one bit per handshake, and emits the reconstructed byte stream.
- Keeps a history window with exactly the same geometry and offset semantics as the compressor, so offset 0 is the oldest byte in the window, not the newest.
- Sits directly downstream of the compressor's outputBit/outputValid/outputReady port, or downstream of a storage/link carrying that stream.

---
 rtl/lz77_pkg.sv | 27 ++
 rtl/lz77_token_deserializer.sv | 52 +++++
 rtl/lz77_decompressor.sv | 214 +++++++++++++++++++++
 tb/tb_lz77_decompressor.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lz77_pkg.sv
// Shared LZ77 definitions: token geometry, flag encodings and the decoder state enum.
// Used by both the compressor and the decompressor so the serial token format stays in step.
package lz77_pkg;

    localparam int LIT_TOKEN_BITS   = 9;
    localparam int MATCH_TOKEN_BITS = 19;

    localparam logic FLAG_LITERAL = 1'b1;
    localparam logic FLAG_MATCH   = 1'b0;

    localparam int LITERAL_BITS = 8;
    localparam int OFFSET_BITS  = 12;
    localparam int LENGTH_BITS  = 6;

    typedef enum logic [3:0] {
        IDLE,
        RECV_FLAG,
        RECV_BODY,
        CHECK,
        COPY_RD,
        COPY_OUT,
        LIT_OUT,
        DONE,
        ERROR
    } lz77State_e;

endpackage

// File: rtl/lz77_token_deserializer.sv
// Serial-to-parallel front end of the LZ77 decompressor: shifts MSB-first token bits,
// counts the body bits left and presents the literal / offset / length fields.
module lz77_token_deserializer
    import lz77_pkg::*;
#(
    parameter int windowAddressBits = OFFSET_BITS,
    parameter int bufferAddressBits = LENGTH_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bitAccept,
    input  logic                         flagPhase,
    input  logic                         bitIn,
    output logic                         isLiteral,
    output logic                         tokenReady,
    output logic [LITERAL_BITS-1:0]      literalByte,
    output logic [windowAddressBits-1:0] matchOffset,
    output logic [bufferAddressBits-1:0] matchLength
);

    localparam int BODY_BITS = windowAddressBits + bufferAddressBits;
    localparam int CNT_BITS  = $clog2(BODY_BITS + 1);

    logic [BODY_BITS-1:0] shiftReg;
    logic [CNT_BITS-1:0]  bitsLeft;

    // The strobe fires on the final body bit; the fields are valid from the following cycle.
    assign tokenReady = bitAccept && !flagPhase && (bitsLeft == CNT_BITS'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            shiftReg  <= '0;
            bitsLeft  <= '0;
            isLiteral <= 1'b0;
        end else if (bitAccept) begin
            if (flagPhase) begin
                isLiteral <= (bitIn == FLAG_LITERAL);
                bitsLeft  <= (bitIn == FLAG_LITERAL) ? CNT_BITS'(LITERAL_BITS) : CNT_BITS'(BODY_BITS);
                shiftReg  <= '0;
            end else begin
                shiftReg <= {shiftReg[BODY_BITS-2:0], bitIn};
                bitsLeft <= bitsLeft - CNT_BITS'(1);
            end
        end
    end

    // A literal leaves its byte in the low bits because the register is cleared on the flag.
    assign literalByte = shiftReg[LITERAL_BITS-1:0];
    assign matchOffset = shiftReg[BODY_BITS-1 -: windowAddressBits];
    assign matchLength = shiftReg[bufferAddressBits-1:0];

endmodule

// File: rtl/lz77_decompressor.sv
// LZ77 decompressor: receives serial tokens, keeps the history window and emits decoded bytes.
// Define LZ77_DECOMP_TOKEN_CHECK_EN to validate match tokens (error output and ERROR state).
module lz77_decompressor
    import lz77_pkg::*;
#(
    parameter int windowSize         = 1023,
    parameter int windowAddressBits  = 12,
    parameter int bufferAddressBits  = 6,
    parameter int minimumMatchLength = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        inputBit,
    input  logic        inputValid,
    output logic        inputReady,
    input  logic        lastTokenPassed,
    output logic [7:0]  outputData,
    output logic        outputValid,
    input  logic        outputReady,
    output logic [31:0] bytesWritten,
    output logic        error
);

    localparam int IDX_BITS = $clog2(windowSize);
    localparam int SUM_BITS = windowAddressBits + 1;
    localparam logic [SUM_BITS-1:0] WINDOW_MOD = SUM_BITS'(windowSize);

`ifdef LZ77_DECOMP_TOKEN_CHECK_EN
    localparam logic TOKEN_CHECK = 1'b1;
`else
    localparam logic TOKEN_CHECK = 1'b0;
`endif

    lz77State_e state, nextState;

    logic [7:0]                   window [windowSize];
    logic [windowAddressBits-1:0] windowPtr;
    logic [windowAddressBits-1:0] charsInWindow;
    logic [windowAddressBits-1:0] srcBase;
    logic [bufferAddressBits-1:0] remaining;
    logic [bufferAddressBits-1:0] copyIndex;
    logic [7:0]                   copyData;
    logic                         lastSeen;
    logic [31:0]                  byteCount;
    logic                         errorReg;

    logic                         tokIsLiteral;
    logic                         tokenReady;
    logic [7:0]                   tokLiteral;
    logic [windowAddressBits-1:0] tokOffset;
    logic [bufferAddressBits-1:0] tokLength;

    logic                         bitAccept;
    logic                         outHandshake;
    logic                         windowFull;
    logic                         malformedToken;
    logic                         goError;
    logic [windowAddressBits-1:0] srcBaseNext;
    logic [IDX_BITS-1:0]          readIndex;
    logic [IDX_BITS-1:0]          writeIndex;
    lz77State_e                   tokenDoneState;

    lz77_token_deserializer #(
        .windowAddressBits(windowAddressBits),
        .bufferAddressBits(bufferAddressBits)
    ) deserializer (
        .clk        (clk),
        .rst        (rst),
        .bitAccept  (bitAccept),
        .flagPhase  (state == RECV_FLAG),
        .bitIn      (inputBit),
        .isLiteral  (tokIsLiteral),
        .tokenReady (tokenReady),
        .literalByte(tokLiteral),
        .matchOffset(tokOffset),
        .matchLength(tokLength)
    );

    assign bitAccept    = inputValid && inputReady;
    assign outHandshake = outputValid && outputReady;

    // Window sums are formed one bit wider than a pointer before the modulo reduction.
    assign windowFull  = ({1'b0, charsInWindow} >= WINDOW_MOD);
    assign srcBaseNext = windowAddressBits'(({1'b0, windowPtr} + {1'b0, tokOffset}) % WINDOW_MOD);
    assign readIndex   = IDX_BITS'(({1'b0, srcBase} + SUM_BITS'(copyIndex)) % WINDOW_MOD);
    assign writeIndex  = windowFull ? IDX_BITS'(windowPtr)
                                    : IDX_BITS'(({1'b0, windowPtr} + {1'b0, charsInWindow}) % WINDOW_MOD);

    assign malformedToken = (tokLength < bufferAddressBits'(minimumMatchLength)) ||
                            (({1'b0, tokOffset} + SUM_BITS'(tokLength)) > {1'b0, charsInWindow});
    assign goError        = TOKEN_CHECK && malformedToken;
    assign tokenDoneState = lastSeen ? DONE : RECV_FLAG;

    // Without the token check errorReg is never set, so error is a constant 0.
    assign error        = errorReg;
    assign bytesWritten = byteCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A zero-length match carries no bytes, so it completes straight from CHECK.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (start) nextState = RECV_FLAG;
            RECV_FLAG: if (bitAccept) nextState = RECV_BODY;
            RECV_BODY: if (tokenReady) nextState = tokIsLiteral ? LIT_OUT : CHECK;
            CHECK: begin
                if (goError) begin
                    nextState = ERROR;
                end else if (tokLength == '0) begin
                    nextState = tokenDoneState;
                end else begin
                    nextState = COPY_RD;
                end
            end
            COPY_RD:   nextState = COPY_OUT;
            COPY_OUT: begin
                if (outHandshake) begin
                    nextState = (remaining > bufferAddressBits'(1)) ? COPY_RD : tokenDoneState;
                end
            end
            LIT_OUT:   if (outHandshake) nextState = tokenDoneState;
            DONE:      nextState = DONE;
            ERROR:     nextState = ERROR;
            default:   nextState = IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        inputReady  = 1'b0;
        outputValid = 1'b0;
        outputData  = copyData;
        case (state)
            RECV_FLAG, RECV_BODY: begin
                busy       = 1'b1;
                inputReady = 1'b1;
            end
            CHECK, COPY_RD: busy = 1'b1;
            COPY_OUT: begin
                busy        = 1'b1;
                outputValid = 1'b1;
            end
            LIT_OUT: begin
                busy        = 1'b1;
                outputValid = 1'b1;
                outputData  = tokLiteral;
            end
            DONE, ERROR: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            windowPtr     <= '0;
            charsInWindow <= '0;
            srcBase       <= '0;
            remaining     <= '0;
            copyIndex     <= '0;
            copyData      <= '0;
            lastSeen      <= 1'b0;
            byteCount     <= '0;
            errorReg      <= 1'b0;
        end else begin
            if (tokenReady && lastTokenPassed) begin
                lastSeen <= 1'b1;
            end
            if (state == CHECK) begin
                srcBase   <= srcBaseNext;
                remaining <= tokLength;
                copyIndex <= '0;
                if (goError) begin
                    errorReg <= 1'b1;
                end
            end
            if (state == COPY_RD) begin
                copyData <= window[readIndex];
            end
            // Once full, the newest byte overwrites the oldest and the window slides forward.
            if (outHandshake) begin
                byteCount <= byteCount + 32'd1;
                if (!windowFull) begin
                    charsInWindow <= charsInWindow + windowAddressBits'(1);
                end else if (windowPtr == windowAddressBits'(windowSize - 1)) begin
                    windowPtr <= '0;
                end else begin
                    windowPtr <= windowPtr + windowAddressBits'(1);
                end
                if (state == COPY_OUT) begin
                    copyIndex <= copyIndex + bufferAddressBits'(1);
                    remaining <= remaining - bufferAddressBits'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && outHandshake) begin
            window[writeIndex] <= outputData;
        end
    end

endmodule

// File: tb/tb_lz77_decompressor.sv
// Self-checking bench for lz77_decompressor: directed and randomized token streams against
// a byte-history reference model. Honours LZ77_DECOMP_TOKEN_CHECK_EN like the design.
module tb_lz77_decompressor;

    localparam int W = 1023;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        inputBit;
    logic        inputValid;
    logic        inputReady;
    logic        lastTokenPassed;
    logic [7:0]  outputData;
    logic        outputValid;
    logic        outputReady;
    logic [31:0] bytesWritten;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int readyMode = 0;
    bit gapMode   = 1'b0;

    logic [7:0] stream[$];
    logic [7:0] gotBytes[$];

    lz77_decompressor dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .inputBit       (inputBit),
        .inputValid     (inputValid),
        .inputReady     (inputReady),
        .lastTokenPassed(lastTokenPassed),
        .outputData     (outputData),
        .outputValid    (outputValid),
        .outputReady    (outputReady),
        .bytesWritten   (bytesWritten),
        .error          (error)
    );

    always #5 clk = ~clk;

    // Sink: picks outputReady for the coming edge and logs every byte that will transfer on it.
    always @(negedge clk) begin
        case (readyMode)
            0:       outputReady = 1'b1;
            1:       outputReady = ($urandom_range(0, 3) != 0);
            default: outputReady = 1'b0;
        endcase
        if (outputValid && outputReady && !rst) gotBytes.push_back(outputData);
    end

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: the decoded stream is the byte history; offset 0 is the oldest window byte.
    task automatic modelLiteral(input logic [7:0] b);
        stream.push_back(b);
    endtask

    task automatic modelMatch(input int off, input int len);
        int base;
        base = (stream.size() > W) ? stream.size() - W : 0;
        for (int k = 0; k < len; k++) stream.push_back(stream[base + off + k]);
    endtask

    function automatic int firstMismatch();
        int n;
        n = (gotBytes.size() < stream.size()) ? gotBytes.size() : stream.size();
        for (int i = 0; i < n; i++) if (gotBytes[i] !== stream[i]) return i;
        if (gotBytes.size() != stream.size()) return n;
        return -1;
    endfunction

    task automatic applyStimulus(input logic b, input logic last);
        int waited = 0;
        if (gapMode) repeat ($urandom_range(0, 2)) begin @(negedge clk); inputValid = 1'b0; end
        @(negedge clk);
        while (!inputReady && waited < 2000) begin
            inputValid = 1'b0;
            waited++;
            @(negedge clk);
        end
        if (!inputReady) begin
            checks++;
            failures++;
            $display("[TB] FAIL bit_accept_timeout: inputReady=%0b required 1", inputReady);
            return;
        end
        inputValid      = 1'b1;
        inputBit        = b;
        lastTokenPassed = last;
        @(posedge clk);
        #1;
        inputValid      = 1'b0;
        lastTokenPassed = 1'b0;
    endtask

    task automatic sendLiteral(input logic [7:0] b, input logic last);
        applyStimulus(1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) applyStimulus(b[i], last && (i == 0));
    endtask

    task automatic sendMatch(input logic [11:0] off, input logic [5:0] len, input logic last);
        applyStimulus(1'b0, 1'b0);
        for (int i = 11; i >= 0; i--) applyStimulus(off[i], 1'b0);
        for (int i = 5; i >= 0; i--) applyStimulus(len[i], last && (i == 0));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; inputValid = 1'b0; lastTokenPassed = 1'b0;
        readyMode = 0; gapMode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        gotBytes.delete();
        stream.delete();
    endtask

    task automatic startStream();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!done && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL done_timeout: done=%0b required 1 after %0d cycles", done, budget);
        end
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({busy, done, inputReady, outputValid, error} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b required 00000", {busy, done, inputReady, outputValid, error});
        end
        checks++;
        if (outputData !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h required 00", outputData);
        end
        checks++;
        if (bytesWritten !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_count: got %0d required 0", bytesWritten);
        end
    endtask

    task automatic test_literal();
        int idx;
        doReset();
        startStream();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL literal_busy_after_start: got %b required 1", busy);
        end
        sendLiteral(8'h41, 1'b1);
        modelLiteral(8'h41);
        waitDone(100);
        idx = firstMismatch();
        checks++;
        if (idx != -1) begin
            failures++;
            $display("[TB] FAIL literal_stream: differs at byte %0d, got %0d bytes required %0d", idx, gotBytes.size(), stream.size());
        end
        checks++;
        if (gotBytes.size() != 1 || gotBytes[0] !== 8'h41) begin
            failures++;
            $display("[TB] FAIL literal_byte: got %0d bytes first %h required 1 byte 41", gotBytes.size(), gotBytes.size() > 0 ? gotBytes[0] : 8'h00);
        end
        checks++;
        if (bytesWritten !== 32'd1) begin
            failures++;
            $display("[TB] FAIL literal_count: got %0d required 1", bytesWritten);
        end
        checks++;
        if ({busy, done} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL literal_done_flags: busy,done got %b required 01", {busy, done});
        end
    endtask

    task automatic test_match();
        int idx;
        logic [7:0] expected [6];
        expected = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
        doReset();
        startStream();
        for (int i = 0; i < 3; i++) begin
            sendLiteral(expected[i], 1'b0);
            modelLiteral(expected[i]);
        end
        sendMatch(12'd0, 6'd3, 1'b1);
        modelMatch(0, 3);
        waitDone(100);
        idx = firstMismatch();
        checks++;
        if (idx != -1) begin
            failures++;
            $display("[TB] FAIL match_stream: differs at byte %0d, got %0d bytes required %0d", idx, gotBytes.size(), stream.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= gotBytes.size() || gotBytes[i] !== expected[i]) begin
                failures++;
                $display("[TB] FAIL match_byte%0d: got %h required %h", i, i < gotBytes.size() ? gotBytes[i] : 8'hxx, expected[i]);
            end
        end
        checks++;
        if (bytesWritten !== 32'd6) begin
            failures++;
            $display("[TB] FAIL match_count: got %0d required 6", bytesWritten);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        int n = 0;
        logic [7:0] held;
        doReset();
        startStream();
        sendLiteral(8'h11, 1'b0); modelLiteral(8'h11);
        sendLiteral(8'h22, 1'b0); modelLiteral(8'h22);
        sendLiteral(8'h33, 1'b0); modelLiteral(8'h33);
        sendMatch(12'd0, 6'd3, 1'b1);
        readyMode = 2;
        modelMatch(0, 3);
        @(negedge clk);
        while (!outputValid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (outputValid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_valid: outputValid got %b required 1", outputValid);
        end
        held = outputData;
        checks++;
        if (held !== 8'h11) begin
            failures++;
            $display("[TB] FAIL bp_first_copy: got %h required 11", held);
        end
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (outputValid !== 1'b1 || outputData !== held) begin
                failures++;
                $display("[TB] FAIL bp_hold: valid %b data %h required valid 1 data %h", outputValid, outputData, held);
            end
            checks++;
            if (inputReady !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_input_ready: got %b required 0", inputReady);
            end
        end
        checks++;
        if (gotBytes.size() != 3) begin
            failures++;
            $display("[TB] FAIL bp_no_transfer: got %0d bytes required 3", gotBytes.size());
        end
        readyMode = 0;
        waitDone(100);
        idx = firstMismatch();
        checks++;
        if (idx != -1) begin
            failures++;
            $display("[TB] FAIL bp_stream: differs at byte %0d, got %0d bytes required %0d", idx, gotBytes.size(), stream.size());
        end
        checks++;
        if (bytesWritten !== 32'd6) begin
            failures++;
            $display("[TB] FAIL bp_count: got %0d required 6", bytesWritten);
        end
    endtask

    task automatic test_window_wrap();
        int idx;
        int sz;
        doReset();
        startStream();
        for (int i = 0; i < W; i++) begin
            sendLiteral(8'(i % 256), 1'b0);
            modelLiteral(8'(i % 256));
        end
        for (int i = 0; i < 5; i++) begin
            sendLiteral(8'hAA, 1'b0);
            modelLiteral(8'hAA);
        end
        sendMatch(12'd0, 6'd4, 1'b1);
        modelMatch(0, 4);
        waitDone(200);
        idx = firstMismatch();
        checks++;
        if (idx != -1) begin
            failures++;
            $display("[TB] FAIL wrap_stream: differs at byte %0d, got %0d bytes required %0d", idx, gotBytes.size(), stream.size());
        end
        sz = gotBytes.size();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (sz < 4 || gotBytes[sz - 4 + j] !== 8'(5 + j)) begin
                failures++;
                $display("[TB] FAIL wrap_copy%0d: got %h required %h", j, sz >= 4 ? gotBytes[sz - 4 + j] : 8'hxx, 8'(5 + j));
            end
        end
        checks++;
        if (bytesWritten !== 32'd1032) begin
            failures++;
            $display("[TB] FAIL wrap_count: got %0d required 1032", bytesWritten);
        end
    endtask

    task automatic test_reset_mid_copy();
        int idx;
        int n = 0;
        doReset();
        startStream();
        for (int i = 0; i < 6; i++) sendLiteral(8'($urandom_range(0, 255)), 1'b0);
        sendMatch(12'd0, 6'd6, 1'b1);
        readyMode = 2;
        @(negedge clk);
        while (!outputValid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (gotBytes.size() != 6 || outputValid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_setup: got %0d bytes valid %b required 6 bytes valid 1", gotBytes.size(), outputValid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, inputReady, outputValid, error} !== 5'b0 || outputData !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: flags %b data %h required 00000 00", {busy, done, inputReady, outputValid, error}, outputData);
        end
        checks++;
        if (bytesWritten !== 32'd0) begin
            failures++;
            $display("[TB] FAIL midreset_count: got %0d required 0", bytesWritten);
        end
        rst = 1'b0;
        readyMode = 0;
        gotBytes.delete();
        stream.delete();
        startStream();
        sendLiteral(8'h5A, 1'b0); modelLiteral(8'h5A);
        sendLiteral(8'h3C, 1'b0); modelLiteral(8'h3C);
        sendLiteral(8'h7E, 1'b0); modelLiteral(8'h7E);
        sendMatch(12'd0, 6'd3, 1'b1);
        modelMatch(0, 3);
        waitDone(100);
        idx = firstMismatch();
        checks++;
        if (idx != -1) begin
            failures++;
            $display("[TB] FAIL midreset_fresh_stream: differs at byte %0d, got %0d bytes required %0d", idx, gotBytes.size(), stream.size());
        end
        checks++;
        if (bytesWritten !== 32'd6) begin
            failures++;
            $display("[TB] FAIL midreset_fresh_count: got %0d required 6", bytesWritten);
        end
    endtask

    task automatic test_random();
        int idx;
        int avail;
        int off;
        int len;
        int maxLen;
        logic [7:0] b;
        logic last;
        doReset();
        readyMode = 1;
        gapMode   = 1'b1;
        startStream();
        for (int t = 0; t < 60; t++) begin
            last = (t == 59);
            if (stream.size() < 3 || $urandom_range(0, 1) == 0) begin
                b = 8'($urandom_range(0, 255));
                sendLiteral(b, last);
                modelLiteral(b);
            end else begin
                avail  = (stream.size() < W) ? stream.size() : W;
                off    = $urandom_range(0, avail - 3);
                maxLen = avail - off;
                if (maxLen > 63) maxLen = 63;
                len    = $urandom_range(3, maxLen);
                sendMatch(12'(off), 6'(len), last);
                modelMatch(off, len);
            end
        end
        waitDone(3000);
        idx = firstMismatch();
        checks++;
        if (idx != -1) begin
            failures++;
            $display("[TB] FAIL random_stream: differs at byte %0d, got %0d bytes required %0d", idx, gotBytes.size(), stream.size());
        end
        checks++;
        if (bytesWritten !== 32'(stream.size())) begin
            failures++;
            $display("[TB] FAIL random_count: got %0d required %0d", bytesWritten, stream.size());
        end
        readyMode = 0;
        gapMode   = 1'b0;
    endtask

    task automatic test_malformed_match();
        doReset();
        startStream();
        sendLiteral(8'h10, 1'b0);
        sendLiteral(8'h20, 1'b0);
        sendMatch(12'd0, 6'd3, 1'b1);
        waitDone(100);
`ifdef LZ77_DECOMP_TOKEN_CHECK_EN
        checks++;
        if ({error, done, busy} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL malformed_flags: error,done,busy got %b required 110", {error, done, busy});
        end
        checks++;
        if (gotBytes.size() != 2 || bytesWritten !== 32'd2) begin
            failures++;
            $display("[TB] FAIL malformed_no_output: got %0d bytes count %0d required 2 and 2", gotBytes.size(), bytesWritten);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({inputReady, outputValid, error} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL malformed_sticky: inputReady,outputValid,error got %b required 001", {inputReady, outputValid, error});
        end
`else
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL unchecked_error: got %b required 0", error);
        end
        checks++;
        if (bytesWritten !== 32'd5) begin
            failures++;
            $display("[TB] FAIL unchecked_count: got %0d required 5", bytesWritten);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        inputBit = 1'b0;
        inputValid = 1'b0;
        lastTokenPassed = 1'b0;
        repeat (2) @(posedge clk);
        $display("[TB] starting lz77_decompressor tests");
        test_reset();
        test_literal();
        test_match();
        test_backpressure();
        test_window_wrap();
        test_reset_mid_copy();
        test_random();
        test_malformed_match();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
